// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if: CPU byte bus plus UART and status signals seen by the memory/IO responder
interface mem_io_responder_if;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        io_buffer_full;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_pop;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_ready;
    logic        program_done;
    logic        tx_overflow;
    modport master (
        output cpu_a, cpu_wr, cpu_wdata, uart_rx_valid, uart_rx_data, uart_tx_ready,
        input  cpu_rdata, io_buffer_full, uart_rx_pop, uart_tx_valid, uart_tx_data, program_done, tx_overflow
    );
    modport slave (
        input  cpu_a, cpu_wr, cpu_wdata, uart_rx_valid, uart_rx_data, uart_tx_ready,
        output cpu_rdata, io_buffer_full, uart_rx_pop, uart_tx_valid, uart_tx_data, program_done, tx_overflow
    );
endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM with one-cycle reads plus UART RX/TX, cycle counter and stop I/O window
module mem_io_responder #(
    parameter int RAM_ADDR_W = 17,
    parameter int TX_DEPTH   = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    mem_io_responder_if.slave bus
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(TX_DEPTH);
    localparam logic [PW:0] ALMOST_CNT = (PW + 1)'(TX_DEPTH - 2);

    logic [7:0]            ram [2**RAM_ADDR_W];
    logic [7:0]            tx_mem [TX_DEPTH];
    logic [RAM_ADDR_W-1:0] ram_a;
    logic                  io, rd, rx_hit, cnt_hit, stop_hit;
    logic [7:0]            ram_q, io_q, io_rdata, snap_byte, push_data;
    logic                  sel_ram;
    logic [31:0]           counter, snapshot;
    logic [PW-1:0]         wp, rp;
    logic [PW:0]           count, count_nx;
    logic                  push_req, push, pop, full;
    logic                  unused_a;

    assign ram_a    = bus.cpu_a[RAM_ADDR_W-1:0];
    assign unused_a = ^bus.cpu_a[31:18];
    assign io       = bus.cpu_a[17:16] == 2'b11;
    assign rd       = !bus.cpu_wr;
    assign rx_hit   = io && bus.cpu_a[15:0] == 16'h0000;
    assign cnt_hit  = io && bus.cpu_a[15:2] == 14'h0001;
    assign stop_hit = io && bus.cpu_a[15:0] == 16'h0004;

    // TX pushes come from non-zero UART writes and from the stop write (which sends a 0x00 marker)
    assign push_req  = bus.cpu_wr && !bus.program_done && ((rx_hit && bus.cpu_wdata != 8'h00) || stop_hit);
    assign push_data = stop_hit ? 8'h00 : bus.cpu_wdata;
    assign full      = count == FULL_CNT;
    assign pop       = bus.uart_tx_valid && bus.uart_tx_ready;
    assign push      = push_req && (!full || pop);
    assign count_nx  = count + (PW + 1)'(push) - (PW + 1)'(pop);

    assign bus.uart_tx_valid = count != '0;
    assign bus.uart_tx_data  = tx_mem[rp];
    assign bus.cpu_rdata     = sel_ram ? ram_q : io_q;

    // I/O read data: offset 0 of the counter window returns the live counter, others the snapshot
    always_comb begin
        snap_byte = counter[7:0];
        if (bus.cpu_a[1:0] == 2'd1) snap_byte = snapshot[15:8];
        if (bus.cpu_a[1:0] == 2'd2) snap_byte = snapshot[23:16];
        if (bus.cpu_a[1:0] == 2'd3) snap_byte = snapshot[31:24];
        io_rdata = rx_hit ? (bus.uart_rx_valid ? bus.uart_rx_data : 8'h00) :
                   cnt_hit ? snap_byte : 8'h00;
    end

    // RAM port: byte write on RAM write cycles, registered read every cycle
    always_ff @(posedge clk_in) begin
        if (bus.cpu_wr && !io) ram[ram_a] <= bus.cpu_wdata;
        ram_q <= ram[ram_a];
    end

    // TX FIFO storage; contents are meaningless once the pointers are reset
    always_ff @(posedge clk_in) begin
        if (push) tx_mem[wp] <= push_data;
    end

    // Control state: read mux select, I/O read data, counter, FIFO pointers and sticky flags
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sel_ram            <= 1'b0;
            io_q               <= 8'h00;
            bus.uart_rx_pop    <= 1'b0;
            counter            <= 32'h0;
            snapshot           <= 32'h0;
            wp                 <= '0;
            rp                 <= '0;
            count              <= '0;
            bus.io_buffer_full <= 1'b0;
            bus.program_done   <= 1'b0;
            bus.tx_overflow    <= 1'b0;
        end else begin
            sel_ram            <= !io;
            io_q               <= rd ? io_rdata : 8'h00;
            bus.uart_rx_pop    <= rd && rx_hit && bus.uart_rx_valid;
            counter            <= counter + 32'h1;
            if (rd && cnt_hit && bus.cpu_a[1:0] == 2'd0) snapshot <= counter;
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count              <= count_nx;
            bus.io_buffer_full <= count_nx >= ALMOST_CNT;
            if (bus.cpu_wr && stop_hit) bus.program_done <= 1'b1;
            if (push_req && full && !pop) bus.tx_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed checks of RAM, UART RX/TX FIFO, counter snapshot and program stop
module tb_mem_io_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    mem_io_responder_if bus();

    mem_io_responder dut (.clk_in(clk), .rst_in(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a);
        bus.cpu_a = a;
        bus.cpu_wr = 1'b0;
        bus.cpu_wdata = 8'h00;
        cyc();
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        bus.cpu_a = a;
        bus.cpu_wr = 1'b1;
        bus.cpu_wdata = d;
        cyc();
    endtask

    initial begin
        bus.cpu_a = 32'h0;
        bus.cpu_wr = 1'b0;
        bus.cpu_wdata = 8'h00;
        bus.uart_rx_valid = 1'b0;
        bus.uart_rx_data = 8'h00;
        bus.uart_tx_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        check("rst_rdata", 32'(bus.cpu_rdata), 32'h0);
        check("rst_rx_pop", 32'(bus.uart_rx_pop), 32'h0);
        check("rst_tx_valid", 32'(bus.uart_tx_valid), 32'h0);
        check("rst_buf_full", 32'(bus.io_buffer_full), 32'h0);
        check("rst_done", 32'(bus.program_done), 32'h0);
        check("rst_ovf", 32'(bus.tx_overflow), 32'h0);

        wr(32'h00010, 8'hA5);
        rd(32'h00010);
        check("ram_rd_10", 32'(bus.cpu_rdata), 32'hA5);
        wr(32'h1FFFF, 8'h3C);
        wr(32'h00011, 8'h5A);
        rd(32'h1FFFF);
        check("ram_rd_1ffff", 32'(bus.cpu_rdata), 32'h3C);
        rd(32'h00011);
        check("ram_rd_11", 32'(bus.cpu_rdata), 32'h5A);
        rd(32'h00010);
        check("ram_rd_10b", 32'(bus.cpu_rdata), 32'hA5);

        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data = 8'h7A;
        rd(32'h30000);
        check("rx_data", 32'(bus.cpu_rdata), 32'h7A);
        check("rx_pop", 32'(bus.uart_rx_pop), 32'h1);
        bus.uart_rx_valid = 1'b0;
        rd(32'h00010);
        check("rx_pop_end", 32'(bus.uart_rx_pop), 32'h0);
        rd(32'h30000);
        check("rx_empty_data", 32'(bus.cpu_rdata), 32'h0);
        check("rx_empty_pop", 32'(bus.uart_rx_pop), 32'h0);
        rd(32'h00010);
        rd(32'h30008);
        check("io_other_rd", 32'(bus.cpu_rdata), 32'h0);

        bus.uart_tx_ready = 1'b1;
        wr(32'h30000, 8'h41);
        check("tx_seq_v1", 32'(bus.uart_tx_valid), 32'h1);
        check("tx_seq_d1", 32'(bus.uart_tx_data), 32'h41);
        wr(32'h30000, 8'h00);
        check("tx_zero_skip", 32'(bus.uart_tx_valid), 32'h0);
        wr(32'h30000, 8'h42);
        check("tx_seq_v2", 32'(bus.uart_tx_valid), 32'h1);
        check("tx_seq_d2", 32'(bus.uart_tx_data), 32'h42);
        rd(32'h00010);
        check("tx_seq_empty", 32'(bus.uart_tx_valid), 32'h0);

        bus.uart_tx_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            wr(32'h30000, 8'(8'h50 + i));
            if (i == 5) check("buf_full_5", 32'(bus.io_buffer_full), 32'h0);
            if (i == 6) check("buf_full_6", 32'(bus.io_buffer_full), 32'h1);
        end
        check("full_head", 32'(bus.uart_tx_data), 32'h51);
        check("full_ovf0", 32'(bus.tx_overflow), 32'h0);
        bus.uart_tx_ready = 1'b1;
        wr(32'h30000, 8'h59);
        check("pushpop_ovf", 32'(bus.tx_overflow), 32'h0);
        bus.uart_tx_ready = 1'b0;
        wr(32'h30000, 8'h5A);
        check("drop_ovf", 32'(bus.tx_overflow), 32'h1);
        bus.uart_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_data", 32'(bus.uart_tx_data), 32'h52 + 32'(i));
            rd(32'h00010);
        end
        check("drain_empty", 32'(bus.uart_tx_valid), 32'h0);
        check("drain_buf_full", 32'(bus.io_buffer_full), 32'h0);

        bus.uart_tx_ready = 1'b0;
        wr(32'h30000, 8'h61);
        wr(32'h30000, 8'h62);
        wr(32'h30000, 8'h63);
        check("pre_rst_valid", 32'(bus.uart_tx_valid), 32'h1);
        bus.cpu_a = 32'h0;
        bus.cpu_wr = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst2_tx_valid", 32'(bus.uart_tx_valid), 32'h0);
        check("rst2_ovf", 32'(bus.tx_overflow), 32'h0);

        repeat (32'h1FF) rd(32'h00000);
        rd(32'h30004);
        check("cnt_b0", 32'(bus.cpu_rdata), 32'hFF);
        rd(32'h00010);
        rd(32'h00010);
        rd(32'h30005);
        check("cnt_b1", 32'(bus.cpu_rdata), 32'h01);
        rd(32'h30006);
        check("cnt_b2", 32'(bus.cpu_rdata), 32'h00);
        rd(32'h30007);
        check("cnt_b3", 32'(bus.cpu_rdata), 32'h00);

        wr(32'h30004, 8'hEE);
        check("stop_done", 32'(bus.program_done), 32'h1);
        check("stop_tx_valid", 32'(bus.uart_tx_valid), 32'h1);
        check("stop_tx_data", 32'(bus.uart_tx_data), 32'h00);
        bus.uart_tx_ready = 1'b1;
        wr(32'h30000, 8'h41);
        check("done_wr_ignored", 32'(bus.uart_tx_valid), 32'h0);
        rd(32'h00010);
        check("done_ram_rd", 32'(bus.cpu_rdata), 32'hA5);
        bus.uart_tx_ready = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst3_done", 32'(bus.program_done), 32'h0);
        check("rst3_rdata", 32'(bus.cpu_rdata), 32'h0);
        check("rst3_tx_valid", 32'(bus.uart_tx_valid), 32'h0);
        rd(32'h00010);
        check("ram_kept_10", 32'(bus.cpu_rdata), 32'hA5);
        rd(32'h1FFFF);
        check("ram_kept_1ffff", 32'(bus.cpu_rdata), 32'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
